// File: rtl/escaneo_teclado_if.sv
// Keypad scanner bus: row pins in, column drive and debounced key report out.
interface escaneo_teclado_if;
  logic [3:0] filas_n;
  logic [3:0] columnas_n;
  logic [3:0] fila;
  logic [3:0] columna;
  logic       tecla_activa;
  logic       tecla_presionada;
  logic       tecla_soltada;

  // Scanner side: samples rows, drives columns and the key report.
  modport master (
    input  filas_n,
    output columnas_n,
    output fila,
    output columna,
    output tecla_activa,
    output tecla_presionada,
    output tecla_soltada
  );

  // Keypad / consumer side.
  modport slave (
    output filas_n,
    input  columnas_n,
    input  fila,
    input  columna,
    input  tecla_activa,
    input  tecla_presionada,
    input  tecla_soltada
  );
endinterface

// File: rtl/escaneo_teclado.sv
// 4x4 keypad scanner: column scan, row synchronizer, press/release debounce.
module escaneo_teclado #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input logic                clk,
  input logic                reset,
  escaneo_teclado_if.master  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ESCANEO,
    REBOTE_PRESION,
    PRESIONADA,
    REBOTE_LIBERACION
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       columnas_n_q, columnas_n_d;
  logic [3:0]       fila_q, fila_d;
  logic [3:0]       columna_q, columna_d;
  logic             activa_q, activa_d;
  logic             presionada_q, presionada_d;
  logic             soltada_q, soltada_d;

  logic [3:0]       filas_s;
  logic [1:0]       low_idx;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign filas_s = sync2_q;

  // Lowest-index row currently pulled low.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!filas_s[i]) low_idx = 2'(i);
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ESCANEO;
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      div_cnt_q    <= '0;
      deb_cnt_q    <= '0;
      columnas_n_q <= 4'b1110;
      fila_q       <= 4'b0000;
      columna_q    <= 4'b0000;
      activa_q     <= 1'b0;
      presionada_q <= 1'b0;
      soltada_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      div_cnt_q    <= div_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      columnas_n_q <= columnas_n_d;
      fila_q       <= fila_d;
      columna_q    <= columna_d;
      activa_q     <= activa_d;
      presionada_q <= presionada_d;
      soltada_q    <= soltada_d;
    end
  end

  // Next-state: scan, debounce press, hold, debounce release.
  always_comb begin
    state_d      = state_q;
    sync1_d      = bus.filas_n;
    sync2_d      = sync1_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    div_cnt_d    = div_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    fila_d       = fila_q;
    columna_d    = columna_q;
    activa_d     = activa_q;
    presionada_d = 1'b0;
    soltada_d    = 1'b0;

    case (state_q)
      ESCANEO: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (filas_s != 4'b1111) begin
            row_idx_d = low_idx;
            deb_cnt_d = '0;
            state_d   = REBOTE_PRESION;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      REBOTE_PRESION: begin
        if (filas_s[row_idx_q]) begin
          // Bounce: give up on this key and move on to the next column.
          div_cnt_d = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ESCANEO;
        end else if (deb_cnt_q == DEB_LAST) begin
          fila_d       = onehot(row_idx_q);
          columna_d    = onehot(col_idx_q);
          activa_d     = 1'b1;
          presionada_d = 1'b1;
          state_d      = PRESIONADA;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      PRESIONADA: begin
        if (filas_s[row_idx_q]) begin
          deb_cnt_d = '0;
          state_d   = REBOTE_LIBERACION;
        end
      end

      REBOTE_LIBERACION: begin
        if (!filas_s[row_idx_q]) begin
          state_d = PRESIONADA;
        end else if (deb_cnt_q == DEB_LAST) begin
          soltada_d = 1'b1;
          fila_d    = 4'b0000;
          columna_d = 4'b0000;
          activa_d  = 1'b0;
          div_cnt_d = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ESCANEO;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: state_d = ESCANEO;
    endcase

    // Column drive tracks the column index on the same edge.
    columnas_n_d = ~onehot(col_idx_d);
  end

  assign bus.columnas_n       = columnas_n_q;
  assign bus.fila             = fila_q;
  assign bus.columna          = columna_q;
  assign bus.tecla_activa     = activa_q;
  assign bus.tecla_presionada = presionada_q;
  assign bus.tecla_soltada    = soltada_q;

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: keypad matrix model plus press/release scoreboard.
module tb_escaneo_teclado;

  localparam int unsigned SCAN_DIV        = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;

  typedef struct packed {
    logic       solt;
    logic [3:0] fila;
    logic [3:0] columna;
  } ev_t;

  logic clk;
  logic reset;
  logic [3:0][3:0] keys;   // keys[row][col] = 1 while that key is held
  ev_t  sb[$];
  int   checks;
  int   errors;

  escaneo_teclado_if bus ();

  escaneo_teclado #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a row is pulled low when a held key sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      bus.filas_n[r] = ~|(keys[r] & ~bus.columnas_n);
    end
  end

  // Advance one cycle, then match any strobe against the scoreboard.
  task automatic tick();
    ev_t exp_ev;
    ev_t got_ev;
    @(posedge clk);
    #1;
    if (bus.tecla_presionada || bus.tecla_soltada) begin
      checks++;
      got_ev = '{bus.tecla_soltada, bus.fila, bus.columna};
      if (bus.tecla_presionada && bus.tecla_soltada) begin
        errors++;
        $display("FAIL strobe_overlap: presionada=1 soltada=1 at %0t", $time);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got solt=%b fila=%b columna=%b, expected none at %0t",
                 got_ev.solt, got_ev.fila, got_ev.columna, $time);
      end else begin
        exp_ev = sb.pop_front();
        if (got_ev !== exp_ev || bus.tecla_activa !== ~exp_ev.solt) begin
          errors++;
          $display("FAIL strobe_payload: got solt=%b fila=%b columna=%b activa=%b, expected solt=%b fila=%b columna=%b activa=%b",
                   got_ev.solt, got_ev.fila, got_ev.columna, bus.tecla_activa,
                   exp_ev.solt, exp_ev.fila, exp_ev.columna, ~exp_ev.solt);
        end
      end
    end
  endtask

  // Bounded wait until every expected strobe has been seen.
  task automatic wait_sb_empty(input string name, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d strobes still pending after %0d cycles, expected 0",
               name, sb.size(), max_cycles);
      sb.delete();
    end
  endtask

  // Bounded wait for the start of a given column slot.
  task automatic wait_col_start(input logic [3:0] col_n);
    int n;
    n = 0;
    while (bus.columnas_n == col_n && n < 64) begin
      tick();
      n++;
    end
    while (bus.columnas_n != col_n && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (bus.columnas_n != col_n) begin
      errors++;
      $display("FAIL wait_col: columnas_n=%b, expected %b", bus.columnas_n, col_n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b1;
    keys  = '0;
    repeat (3) tick();
    checks++;
    if (bus.columnas_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_columnas: got %b, expected 1110", bus.columnas_n);
    end
    checks++;
    if (bus.fila !== 4'b0000 || bus.columna !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fila_columna: got fila=%b columna=%b, expected 0000 0000", bus.fila, bus.columna);
    end
    checks++;
    if ({bus.tecla_activa, bus.tecla_presionada, bus.tecla_soltada} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000",
               {bus.tecla_activa, bus.tecla_presionada, bus.tecla_soltada});
    end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3 || (k % 4) == 0) begin
        exp_col = ~(4'b0001 << ((k / 4) % 4));
        checks++;
        if (bus.columnas_n !== exp_col) begin
          errors++;
          $display("FAIL scan_sequence: cycle %0d got columnas_n=%b, expected %b", k, bus.columnas_n, exp_col);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int drops;
    int lat;
    sb.push_back('{1'b0, 4'b0100, 4'b0010});
    keys[2][1] = 1'b1;
    wait_sb_empty("clean_press", 60);
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tecla_activa !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0 || bus.fila !== 4'b0100 || bus.columna !== 4'b0010) begin
      errors++;
      $display("FAIL clean_hold: activa low %0d cycles fila=%b columna=%b, expected 0 cycles 0100 0010",
               drops, bus.fila, bus.columna);
    end
    sb.push_back('{1'b1, 4'b0000, 4'b0000});
    keys[2][1] = 1'b0;
    lat = 0;
    while (sb.size() != 0 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat < int'(DEBOUNCE_CYCLES) + 2 || lat > int'(DEBOUNCE_CYCLES) + 3) begin
      errors++;
      $display("FAIL release_latency: got %0d cycles, expected %0d..%0d",
               lat, DEBOUNCE_CYCLES + 2, DEBOUNCE_CYCLES + 3);
      sb.delete();
    end
    tick();
    checks++;
    if (bus.fila !== 4'b0000 || bus.columna !== 4'b0000 || bus.tecla_activa !== 1'b0) begin
      errors++;
      $display("FAIL after_release: got fila=%b columna=%b activa=%b, expected 0000 0000 0",
               bus.fila, bus.columna, bus.tecla_activa);
    end
  endtask

  task automatic test_press_bounce();
    wait_col_start(4'b1101);
    keys[2][1] = 1'b1;
    repeat (3) tick();
    keys[2][1] = 1'b0;
    repeat (2) tick();
    sb.push_back('{1'b0, 4'b0100, 4'b0010});
    keys[2][1] = 1'b1;
    wait_sb_empty("bounce_press", 100);
    repeat (5) tick();
    sb.push_back('{1'b1, 4'b0000, 4'b0000});
    keys[2][1] = 1'b0;
    wait_sb_empty("bounce_release", 40);
  endtask

  task automatic test_release_bounce();
    int drops;
    sb.push_back('{1'b0, 4'b0001, 4'b1000});
    keys[0][3] = 1'b1;
    wait_sb_empty("relb_press", 60);
    keys[0][3] = 1'b0;
    repeat (4) tick();
    keys[0][3] = 1'b1;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tecla_activa !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0 || bus.fila !== 4'b0001 || bus.columna !== 4'b1000) begin
      errors++;
      $display("FAIL release_bounce_hold: activa low %0d cycles fila=%b columna=%b, expected 0 cycles 0001 1000",
               drops, bus.fila, bus.columna);
    end
    sb.push_back('{1'b1, 4'b0000, 4'b0000});
    keys[0][3] = 1'b0;
    wait_sb_empty("relb_release", 40);
  endtask

  task automatic test_multi_key();
    sb.push_back('{1'b0, 4'b0010, 4'b0001});
    keys[1][0] = 1'b1;
    keys[3][0] = 1'b1;
    wait_sb_empty("multi_first", 60);
    keys[2][2] = 1'b1;
    repeat (30) tick();
    checks++;
    if (bus.fila !== 4'b0010 || bus.columna !== 4'b0001) begin
      errors++;
      $display("FAIL multi_second_ignored: got fila=%b columna=%b, expected 0010 0001", bus.fila, bus.columna);
    end
    sb.push_back('{1'b1, 4'b0000, 4'b0000});
    sb.push_back('{1'b0, 4'b0100, 4'b0100});
    keys[1][0] = 1'b0;
    keys[3][0] = 1'b0;
    wait_sb_empty("multi_second", 150);
    sb.push_back('{1'b1, 4'b0000, 4'b0000});
    keys[2][2] = 1'b0;
    wait_sb_empty("multi_release", 40);
  endtask

  task automatic test_reset_mid();
    sb.push_back('{1'b0, 4'b1000, 4'b0010});
    keys[3][1] = 1'b1;
    wait_sb_empty("rst_press", 60);
    reset = 1'b1;
    tick();
    checks++;
    if (bus.columnas_n !== 4'b1110 || bus.fila !== 4'b0000 || bus.columna !== 4'b0000 ||
        {bus.tecla_activa, bus.tecla_presionada, bus.tecla_soltada} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: got columnas_n=%b fila=%b columna=%b flags=%b, expected 1110 0000 0000 000",
               bus.columnas_n, bus.fila, bus.columna,
               {bus.tecla_activa, bus.tecla_presionada, bus.tecla_soltada});
    end
    keys[3][1] = 1'b0;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    checks++;
    if (bus.tecla_activa !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got activa=%b, expected 0", bus.tecla_activa);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = '0;
    reset  = 1'b1;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_multi_key();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/escaneo_teclado.md
Name: escaneo_teclado

Overview:
- Upstream keypad front end for the 4x4 hex calculator.
- Drives the keypad columns, samples the rows, and debounces both press and release.
- Delivers a stable one-hot fila/columna pair plus press/release strobes to the keypad encoder and the reading subsystem.
- All outputs are registered; a 2-flop synchronizer sits on the row inputs.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven during scanning (>=2).
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a press or a release (>=2).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
filas_n  input  4  keypad row pins, active-low (pulled up), asynchronous.
columnas_n  output  4  keypad column drive, active-low one-hot.
fila  output  4  one-hot active-high row of the accepted key; 0 when no key.
columna  output  4  one-hot active-high column of the accepted key; 0 when no key.
tecla_activa  output  1  level, high while a debounced key is held.
tecla_presionada  output  1  1-cycle pulse on debounced press.
tecla_soltada  output  1  1-cycle pulse on debounced release.

Behaviour:
- Reset values:
  - columnas_n = 4'b1110 (column 0 driven); fila = 0; columna = 0.
  - tecla_activa, tecla_presionada, tecla_soltada = 0.
  - Synchronizer flops = 4'b1111; col_idx = 0; div_cnt = 0; deb_cnt = 0; state = ESCANEO.
- Reset mid-operation returns to this state on the next edge with no strobe emitted.
- filas_s is the 2-flop synchronized filas_n. All decisions below use filas_s.
- ESCANEO:
  - div_cnt increments every cycle.
  - When div_cnt == SCAN_DIV-1, filas_s is sampled.
  - If any bit of filas_s is 0: latch the lowest-index low row as row_idx, keep col_idx, clear deb_cnt, go to REBOTE_PRESION.
  - Otherwise: div_cnt <= 0 and col_idx <= col_idx+1 (wraps 3->0). columnas_n follows col_idx on the same edge.
- REBOTE_PRESION: column drive frozen.
  - If filas_s[row_idx] == 0: deb_cnt++.
  - If filas_s[row_idx] == 1 before the count completes (bounce): return to ESCANEO. Clear div_cnt, advance col_idx, emit no strobe.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with the row still low: go to PRESIONADA. In that first PRESIONADA cycle, fila = onehot(row_idx), columna = onehot(col_idx), tecla_activa = 1, and tecla_presionada = 1 for exactly one cycle.
- PRESIONADA:
  - Outputs held stable.
  - When filas_s[row_idx] == 1: clear deb_cnt and go to REBOTE_LIBERACION.
  - Other rows are ignored.
- REBOTE_LIBERACION:
  - fila, columna and tecla_activa are held.
  - If filas_s[row_idx] == 0: return to PRESIONADA with no new press pulse.
  - If the row stays high and deb_cnt reaches DEBOUNCE_CYCLES-1: tecla_soltada = 1 for one cycle, and fila, columna and tecla_activa clear in that same cycle. Then go to ESCANEO, resuming at col_idx+1 with div_cnt = 0.
- Latency: debounced press appears 2 (sync) + 1 (sample) + DEBOUNCE_CYCLES cycles after the pin goes low inside a column slot. Release latency follows the same rule.
- Multiple keys:
  - Lowest row index wins within a column.
  - The first column scanned wins across columns.
  - A second key pressed while one is held is ignored. Its press is recognised only after the first key is released and scanning resumes.
- tecla_presionada and tecla_soltada are never high in the same cycle.
- At most one tecla_soltada per tecla_presionada, and strictly after it.
- Counters are sized to hold SCAN_DIV-1 and DEBOUNCE_CYCLES-1 without overflow.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Reset held 3 cycles with filas_n=1111 -> columnas_n=1110, all outputs 0; columns then cycle 1110,1101,1011,0111,1110 every 4 cycles.
2. Clean press of row 2 / col 1, held 40 cycles, then released -> exactly one tecla_presionada with fila=0100 and columna=0010; tecla_activa high throughout; one tecla_soltada 8+3 cycles after release; fila=columna=0 afterwards.
3. Press bounce: row low 3 cycles, high 2, low 20 -> no pulse from the first burst; single tecla_presionada after the final stable period.
4. Release bounce: during a hold, row goes high 4 cycles then low again -> no tecla_soltada, tecla_activa stays 1, no second press pulse.
5. Rows 1 and 3 low simultaneously in column 0 -> fila=0010. A second key in column 2 pressed while holding is ignored until the first is released, then that key is reported.
6. Reset asserted in PRESIONADA -> next edge all outputs 0, columnas_n=1110, no tecla_soltada emitted.
